// File: rtl/pipelined_adder_pkg.sv
// Shared types and helpers for the chunked, carry-pipelined adder.
package pipelined_adder_pkg;

    // Widest operand the stage record can carry.
    localparam int unsigned MAX_WIDTH = 64;

    // Per-stage view: valid bit, carry out of the chunk, de-skewed partial
    // sum (chunks 0..k) and the skewed operands travelling with the slot.
    typedef struct packed {
        logic                 valid;
        logic                 carry;
        logic [MAX_WIDTH-1:0] sum;
        logic [MAX_WIDTH-1:0] a;
        logic [MAX_WIDTH-1:0] b;
    } stage_rec_t;

    // Pipeline depth (and latency in cycles).
    function automatic int unsigned stages_f(input int unsigned width,
                                             input int unsigned chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/adder_stage.sv
// One CHUNK-wide registered add with carry in/out and a hold enable.
module adder_stage #(
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             c_i,
    output logic [CHUNK-1:0] s_o,
    output logic             c_o,
    output logic             cm_o
);

    logic [CHUNK-1:0] s_q, s_d;
    logic             c_q, c_d;
    logic             cm_q, cm_d;

    // Chunk sum, carry out, and carry into the chunk MSB (for overflow).
    always_comb begin
        {c_d, s_d} = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, c_i};
        cm_d       = s_d[CHUNK-1] ^ a_i[CHUNK-1] ^ b_i[CHUNK-1];
    end

    // Result register: cleared by reset, held while the pipeline stalls.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s_q  <= '0;
            c_q  <= 1'b0;
            cm_q <= 1'b0;
        end else if (en_i) begin
            s_q  <= s_d;
            c_q  <= c_d;
            cm_q <= cm_d;
        end
    end

    assign s_o  = s_q;
    assign c_o  = c_q;
    assign cm_o = cm_q;

endmodule

// File: rtl/pipelined_adder.sv
// Carry-pipelined adder/subtractor: one CHUNK per stage, STAGES cycles of
// latency, valid/ready flow control with a single global advance enable.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CHUNK = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C_IN,
    input  logic             SUB,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] Y,
    output logic             C_OUT,
    output logic             V
);

    localparam int unsigned STAGES = stages_f(WIDTH, CHUNK);
    localparam int unsigned LAST   = STAGES - 1;

    logic                     adv;
    logic [WIDTH-1:0]         b_eff;
    stage_rec_t [STAGES-1:0]  stage_w;
    logic [STAGES-1:0]        cm_w;

    assign b_eff = SUB ? ~B : B;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             valid_q, valid_d;
        logic [WIDTH-1:0] opa_q, opa_d;
        logic [WIDTH-1:0] opb_q, opb_d;
        logic [WIDTH-1:0] lo_q, lo_d;
        logic             c_in;
        logic [CHUNK-1:0] s;
        logic             c;
        logic             cm;
        stage_rec_t       view;

        if (k == 0) begin : g_head
            // Stage 0 loads the new transaction straight from the ports.
            always_comb begin
                valid_d = IN_VALID;
                opa_d   = A;
                opb_d   = b_eff;
                lo_d    = '0;
                c_in    = C_IN;
            end
        end else begin : g_body
            // Later stages take the slot, operands, lower sum and carry of k-1.
            always_comb begin
                valid_d = stage_w[k-1].valid;
                opa_d   = stage_w[k-1].a[WIDTH-1:0];
                opb_d   = stage_w[k-1].b[WIDTH-1:0];
                lo_d    = stage_w[k-1].sum[WIDTH-1:0];
                c_in    = stage_w[k-1].carry;
            end
        end

        // Slot register: valid, skewed operands and de-skewed lower sum.
        always_ff @(posedge CLK) begin
            if (RST) begin
                valid_q <= 1'b0;
                opa_q   <= '0;
                opb_q   <= '0;
                lo_q    <= '0;
            end else if (adv) begin
                valid_q <= valid_d;
                opa_q   <= opa_d;
                opb_q   <= opb_d;
                lo_q    <= lo_d;
            end
        end

        adder_stage #(
            .CHUNK (CHUNK)
        ) u_add (
            .clk_i (CLK),
            .rst_i (RST),
            .en_i  (adv),
            .a_i   (opa_d[k*CHUNK +: CHUNK]),
            .b_i   (opb_d[k*CHUNK +: CHUNK]),
            .c_i   (c_in),
            .s_o   (s),
            .c_o   (c),
            .cm_o  (cm)
        );

        // Merge this stage's chunk into the de-skewed sum seen downstream.
        always_comb begin
            view                       = '0;
            view.valid                 = valid_q;
            view.carry                 = c;
            view.sum[WIDTH-1:0]        = lo_q;
            view.sum[k*CHUNK +: CHUNK] = s;
            view.a[WIDTH-1:0]          = opa_q;
            view.b[WIDTH-1:0]          = opb_q;
        end

        assign stage_w[k] = view;
        assign cm_w[k]    = cm;
    end

    assign OUT_VALID = stage_w[LAST].valid;
    assign Y         = stage_w[LAST].sum[WIDTH-1:0];
    assign C_OUT     = stage_w[LAST].carry;
    assign V         = cm_w[LAST] ^ stage_w[LAST].carry;

    // Whole pipeline moves together; reset blocks acceptance outright.
    assign adv      = OUT_READY | ~OUT_VALID;
    assign IN_READY = adv & ~RST;

    // Record bits above WIDTH and inner-stage MSB carries are never consumed.
    logic unused_view;
    assign unused_view = ^{stage_w, cm_w};

endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits.
REQ-002 Parameter CHUNK, default 4: bits added per pipeline stage; WIDTH SHALL be a multiple of CHUNK.
REQ-003 Derived constant STAGES = WIDTH/CHUNK SHALL be the pipeline depth and the latency in cycles.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 CLK  input  1  clock, all state updates on the rising edge.
REQ-006 RST  input  1  synchronous active-high reset.
REQ-007 IN_VALID  input  1  operands on A, B, C_IN and SUB are valid.
REQ-008 IN_READY  output  1  block accepts operands this cycle.
REQ-009 A  input  WIDTH  first operand.
REQ-010 B  input  WIDTH  second operand.
REQ-011 C_IN  input  1  carry into bit 0.
REQ-012 SUB  input  1  0 selects add, 1 selects add of the bitwise complement of B.
REQ-013 OUT_VALID  output  1  result on Y, C_OUT and V is valid.
REQ-014 OUT_READY  input  1  consumer takes the result this cycle.
REQ-015 Y  output  WIDTH  sum.
REQ-016 C_OUT  output  1  carry out of bit WIDTH-1.
REQ-017 V  output  1  two's-complement signed overflow.

Function
REQ-018 Arithmetic: {C_OUT, Y} SHALL equal A + (SUB ? ~B : B) + C_IN, computed modulo 2^(WIDTH+1).
REQ-019 V SHALL be 1 iff the carry into bit WIDTH-1 differs from C_OUT.
REQ-020 Stage k (0..STAGES-1) SHALL add chunk k of the operands plus the carry registered by stage k-1; stage 0 takes C_IN.
REQ-021 Upper operand chunks SHALL be skew-registered alongside the data, and lower result chunks SHALL be de-skew-registered, so Y, C_OUT and V for one transaction appear together.
REQ-022 Each stage SHALL carry a valid bit; a transaction accepted in cycle t SHALL reach OUT_VALID=1 in cycle t+STAGES when no stall occurs.
REQ-023 Pipeline advance enable: ADV = OUT_READY or not OUT_VALID.
REQ-024 IN_READY SHALL equal ADV, as a combinational signal with no dependence on IN_VALID.
REQ-025 When ADV=0, every stage register, valid bit and output SHALL hold its value.
REQ-026 When ADV=1, every stage SHALL shift forward one position, and stage 0 SHALL load IN_VALID together with the operands.
REQ-027 Y, C_OUT and V SHALL be held stable while OUT_VALID=1 and OUT_READY=0.
REQ-028 Bubbles are permitted: IN_VALID=0 while ADV=1 SHALL insert an invalid slot, and output ordering SHALL be strict FIFO.
REQ-029 Full throughput: with OUT_READY held at 1, one result per cycle SHALL be sustained.
REQ-030 Simultaneous output handshake and input acceptance in the same cycle SHALL lose no transaction and duplicate none.
REQ-031 Data registers in slots whose valid bit is 0 are don't-care; outputs are only meaningful when OUT_VALID=1.

Reset
REQ-032 RST=1 SHALL clear all valid bits, so OUT_VALID=0 in the following cycle.
REQ-033 RST=1 SHALL set Y=0, C_OUT=0 and V=0.
REQ-034 RST asserted mid-operation SHALL discard all in-flight transactions, and no result from them SHALL appear.
REQ-035 While RST=1, IN_READY SHALL be 0, and a transaction presented then SHALL not be accepted.

Structure
REQ-036 A shared package SHALL hold the stage-record typedef (valid, carry, partial sum, skewed operands) and the STAGES derivation function.
REQ-037 One sub-module SHALL be used: adder_stage, a CHUNK-wide registered add with carry-in, carry-out and hold enable, instantiated STAGES times.

Verification
REQ-038 Test 1, WIDTH=8, CHUNK=4: A=0x7F, B=0x01, C_IN=0, SUB=0, accepted cycle 0 -> OUT_VALID in cycle 2, Y=0x80, C_OUT=0, V=1.
REQ-039 Test 2, subtract: A=0x05, B=0x07, C_IN=1, SUB=1 -> Y=0xFE, C_OUT=0, V=0; A=0x80, B=0x01, C_IN=1, SUB=1 -> Y=0x7F, C_OUT=1, V=1.
REQ-040 Test 3, carry across the chunk boundary: A=0xFF, B=0x00, C_IN=1 -> Y=0x00, C_OUT=1, V=0.
REQ-041 Test 4, backpressure: stream 10 random transactions with OUT_READY toggled pseudo-randomly -> results in order, no loss or duplication, and outputs stable while stalled.
REQ-042 Test 5, reset mid-stream: assert RST for one cycle with 2 transactions in flight -> OUT_VALID=0 the next cycle, and neither result ever appears.
REQ-043 Test 6, generality: repeat Tests 1-4 with WIDTH=16, CHUNK=4 -> latency is 4 cycles and every result matches REQ-018 and REQ-019.
